cam_rx_chk: RTL and testbench

Receive-side checker for the CAM compare interface. It sits beside the CAM, opposite the stimulus generator, and consumes the CAM match outputs. Each compare issued by the generator carries an expected result. The block aligns that expectation to the CAM result after a fixed lookup latency, checks it, counts outcomes, and holds a record of the first error. It is synthesisable so it can be reused as an on-chip self-test monitor.

---
 rtl/cam_rx_chk.sv | 137 +++++++++++++
 tb/tb_cam_rx_chk.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/cam_rx_chk.sv
// cam_rx_chk: aligns expected CAM compare results to the CAM outputs, checks them and keeps statistics
module cam_rx_chk #(
    parameter int DATA_WIDTH    = 24,
    parameter int ADDR_WIDTH    = 9,
    parameter int MATCH_LATENCY = 2,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     compare_valid,
    input  logic [DATA_WIDTH-1:0]    compare_data,
    input  logic                     exp_hit,
    input  logic [ADDR_WIDTH-1:0]    exp_addr,
    input  logic                     write_busy,
    input  logic                     match,
    input  logic [ADDR_WIDTH-1:0]    match_addr,
    input  logic [2**ADDR_WIDTH-1:0] match_many,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     hit_cnt,
    output logic [CNT_WIDTH-1:0]     miss_cnt,
    output logic [CNT_WIDTH-1:0]     skip_cnt,
    output logic [CNT_WIDTH-1:0]     multi_cnt,
    output logic [CNT_WIDTH-1:0]     err_cnt,
    output logic                     err_flag,
    output logic [DATA_WIDTH-1:0]    err_data,
    output logic [ADDR_WIDTH-1:0]    err_addr
);
    localparam int L     = MATCH_LATENCY;
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state, state_nxt;
    logic [L-1:0]            pv, ps, ph, pv_sh;
    logic [DATA_WIDTH-1:0]   pd [L];
    logic [ADDR_WIDTH-1:0]   pa [L];
    logic                    take_start, capture, drain_empty;
    logic                    chk_v, checked, mism, multi;

    assign take_start  = start && (state == IDLE || state == DONE);
    assign capture     = compare_valid && state == RUN;
    assign pv_sh       = pv << 1;
    // DRAIN ends as the last entry is checked, so counters are final when done rises
    assign drain_empty = pv_sh == '0;
    assign chk_v       = pv[L-1];
    assign checked     = chk_v && !ps[L-1];
    assign mism        = checked && ((match != ph[L-1]) ||
                         (ph[L-1] && match && match_addr != pa[L-1]));
    assign busy        = state == RUN || state == DRAIN;
    assign done        = state == DONE;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // any-two-bits-set detector: a bit set while some lower bit was already set
    always_comb begin
        logic seen;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            multi = multi | (seen & match_many[i]);
            seen  = seen | match_many[i];
        end
    end

    // next-state logic; stop in RUN wins because start is only taken in IDLE/DONE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = stop ? DRAIN : RUN;
            DRAIN:   state_nxt = drain_empty ? DONE : DRAIN;
            default: state_nxt = start ? RUN : DONE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // alignment pipeline: expectation travels MATCH_LATENCY stages to meet the CAM result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pv <= '0;
            ps <= '0;
            ph <= '0;
            for (int i = 0; i < L; i++) begin
                pd[i] <= '0;
                pa[i] <= '0;
            end
        end else begin
            for (int i = L - 1; i > 0; i--) begin
                pv[i] <= pv[i-1];
                ps[i] <= ps[i-1];
                ph[i] <= ph[i-1];
                pd[i] <= pd[i-1];
                pa[i] <= pa[i-1];
            end
            pv[0] <= capture;
            ps[0] <= write_busy;
            ph[0] <= exp_hit;
            pd[0] <= compare_data;
            pa[0] <= exp_addr;
        end
    end

    // saturating statistics and first-error record, cleared when a start is taken
    always_ff @(posedge clk or negedge rst) begin
        if (!rst || take_start) begin
            hit_cnt   <= '0;
            miss_cnt  <= '0;
            skip_cnt  <= '0;
            multi_cnt <= '0;
            err_cnt   <= '0;
            err_flag  <= 1'b0;
            err_data  <= '0;
            err_addr  <= '0;
        end else begin
            if (chk_v && ps[L-1]) skip_cnt <= sat_inc(skip_cnt);
            if (checked && match) hit_cnt <= sat_inc(hit_cnt);
            if (checked && !match) miss_cnt <= sat_inc(miss_cnt);
            if (checked && multi) multi_cnt <= sat_inc(multi_cnt);
            if (mism) err_cnt <= sat_inc(err_cnt);
            if (mism && !err_flag) begin
                err_flag <= 1'b1;
                err_data <= pd[L-1];
                err_addr <= match_addr;
            end
        end
    end
endmodule

// File: tb/tb_cam_rx_chk.sv
// tb_cam_rx_chk: directed scoreboard bench; expected statistics are checked when done rises
module tb_cam_rx_chk;
    localparam int DW = 24, AW = 9, L = 2, CW = 4, DEPTH = 512;

    logic clk = 0, rst = 0, start = 0, stop = 0, compare_valid = 0;
    logic [DW-1:0] compare_data = '0;
    logic exp_hit = 0, write_busy = 0;
    logic [AW-1:0] exp_addr = '0;
    logic match;
    logic [AW-1:0] match_addr;
    logic [DEPTH-1:0] match_many;
    logic busy, done, err_flag;
    logic [CW-1:0] hit_cnt, miss_cnt, skip_cnt, multi_cnt, err_cnt;
    logic [DW-1:0] err_data;
    logic [AW-1:0] err_addr;

    typedef struct packed {logic m; logic [AW-1:0] a; logic [DEPTH-1:0] mm;} cam_t;
    typedef struct {int hit; int miss; int skip; int multi; int err; int flag; int data; int addr;} exp_t;

    cam_t cr = '0;
    cam_t dl [L];
    exp_t sb [$];
    int n_cmp = 0, n_bad = 0;

    cam_rx_chk #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATCH_LATENCY(L), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .compare_valid(compare_valid),
        .compare_data(compare_data), .exp_hit(exp_hit), .exp_addr(exp_addr),
        .write_busy(write_busy), .match(match), .match_addr(match_addr),
        .match_many(match_many), .busy(busy), .done(done), .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt), .skip_cnt(skip_cnt), .multi_cnt(multi_cnt), .err_cnt(err_cnt),
        .err_flag(err_flag), .err_data(err_data), .err_addr(err_addr)
    );

    always #5 clk = ~clk;

    // CAM model: returns the response given with a compare L cycles later
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < L; i++) dl[i] <= '0;
        end else begin
            dl[0] <= cr;
            for (int i = 1; i < L; i++) dl[i] <= dl[i-1];
        end
    end
    assign {match, match_addr, match_many} = dl[L-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        n_cmp++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, ex);
        end
    endtask

    // monitor: every rising done pops one expected record
    always @(negedge clk) begin : mon
        exp_t e;
        logic done_q;
        if (done === 1'b1 && done_q !== 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_underflow: done rose with no expected record");
            end else begin
                e = sb.pop_front();
                chk("hit_cnt", 32'(hit_cnt), e.hit);
                chk("miss_cnt", 32'(miss_cnt), e.miss);
                chk("skip_cnt", 32'(skip_cnt), e.skip);
                chk("multi_cnt", 32'(multi_cnt), e.multi);
                chk("err_cnt", 32'(err_cnt), e.err);
                chk("err_flag", 32'(err_flag), e.flag);
                chk("err_data", 32'(err_data), e.data);
                chk("err_addr", 32'(err_addr), e.addr);
                chk("busy_at_done", 32'(busy), 0);
            end
        end
        done_q = done;
    end

    function automatic logic [DEPTH-1:0] oh(input int a);
        logic [DEPTH-1:0] one;
        one = 1;
        return one << a;
    endfunction

    task automatic push(input int h, mi, s, mu, er, f, d, a);
        sb.push_back('{h, mi, s, mu, er, f, d, a});
    endtask

    task automatic cmp(input logic [DW-1:0] k, input logic eh, input logic [AW-1:0] ea,
                       input logic wb, input logic m, input logic [AW-1:0] ma,
                       input logic [DEPTH-1:0] mm, input logic stp);
        @(negedge clk);
        compare_valid = 1; compare_data = k; exp_hit = eh; exp_addr = ea;
        write_busy = wb; stop = stp; cr = {m, ma, mm};
        @(posedge clk);
        #1;
        compare_valid = 0; stop = 0; write_busy = 0; cr = '0;
    endtask

    task automatic hit(input int k, input int a);
        cmp(DW'(k), 1, AW'(a), 0, 1, AW'(a), oh(a), 0);
    endtask

    task automatic go();
        @(negedge clk); start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic halt();
        @(negedge clk); stop = 1;
        @(posedge clk); #1 stop = 0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        if (n == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: done still %0b after 12 cycles", done);
            n = 99;
        end
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_hit"}, 32'(hit_cnt), 0);
        chk({tag, "_miss"}, 32'(miss_cnt), 0);
        chk({tag, "_skip"}, 32'(skip_cnt), 0);
        chk({tag, "_multi"}, 32'(multi_cnt), 0);
        chk({tag, "_err"}, 32'(err_cnt), 0);
        chk({tag, "_flag"}, 32'(err_flag), 0);
        chk({tag, "_data"}, 32'(err_data), 0);
        chk({tag, "_addr"}, 32'(err_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #12;
        all_zero("reset");
        @(negedge clk) rst = 1;
        // ten hits at addresses 0..9
        go();
        for (int i = 0; i < 10; i++) hit(i, i);
        push(10, 0, 0, 0, 0, 0, 0, 0);
        halt();
        wait_done(n);
        chk("t1_done_within_2", 32'(n <= 2), 1);
        // wrong address, then unexpected hit: first error record kept
        go();
        cmp(24'h00ABCD, 1, 5, 0, 1, 7, oh(7), 0);
        cmp(24'h001234, 0, 0, 0, 1, 3, oh(3), 0);
        push(2, 0, 0, 0, 2, 1, 'hABCD, 7);
        halt();
        wait_done(n);
        // compares during write_busy are skipped, not checked
        go();
        for (int i = 0; i < 4; i++) cmp(DW'(i), 1, 1, 1, 0, 0, '0, 0);
        push(0, 0, 4, 0, 0, 0, 0, 0);
        halt();
        wait_done(n);
        // multi-match detection plus one clean miss
        go();
        cmp(1, 1, 3, 0, 1, 3, oh(3) | oh(200), 0);
        cmp(2, 1, 3, 0, 1, 3, oh(3), 0);
        cmp(3, 0, 0, 0, 0, 0, '0, 0);
        push(2, 1, 0, 1, 0, 0, 0, 0);
        halt();
        wait_done(n);
        // stop with the last compare; a compare during DRAIN is ignored
        go();
        push(3, 0, 0, 0, 0, 0, 0, 0);
        hit(1, 1);
        hit(2, 2);
        cmp(3, 1, 3, 0, 1, 3, oh(3), 1);
        cmp(4, 1, 4, 0, 0, 0, '0, 0);
        chk("t5_busy_drain", 32'(busy), 1);
        wait_done(n);
        chk("t5_drain_latency", 32'(n + 1 <= L + 1), 1);
        // saturation of 4-bit hit counter
        go();
        for (int i = 0; i < 20; i++) hit(i, i);
        push(15, 0, 0, 0, 0, 0, 0, 0);
        halt();
        wait_done(n);
        // reset mid-run clears everything; without start nothing is counted
        go();
        for (int i = 0; i < 3; i++) hit(i, i);
        @(negedge clk) rst = 0;
        #1;
        all_zero("midrst");
        @(negedge clk) rst = 1;
        hit(9, 9);
        repeat (4) @(negedge clk);
        chk("idle_hit", 32'(hit_cnt), 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
